stopwatch_ctrl: RTL and testbench

Front-panel controller that sequences the centisecond stopwatch datapath. It turns three debounced push-button levels into run/pause/clear control (sw_en, sw_clr) and adds a lap function. A lap freezes a captured copy of the six BCD digits on the display for a programmable hold time while the stopwatch keeps counting. It sits between the button debouncers and the stopwatch/seven-segment display path.

---
 rtl/stopwatch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Front-panel sequencer for the centisecond stopwatch: run/pause/
//            clear control plus a lap capture that freezes the display.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int LAP_HOLD = 300_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    input  logic [3:0] d5_in,
    input  logic [3:0] d4_in,
    input  logic [3:0] d3_in,
    input  logic [3:0] d2_in,
    input  logic [3:0] d1_in,
    input  logic [3:0] d0_in,
    output logic       sw_en,
    output logic       sw_clr,
    output logic [3:0] disp_d5,
    output logic [3:0] disp_d4,
    output logic [3:0] disp_d3,
    output logic [3:0] disp_d2,
    output logic [3:0] disp_d1,
    output logic [3:0] disp_d0,
    output logic       disp_frozen,
    output logic [3:0] lap_num
);

    localparam int                HOLD_W      = $clog2(LAP_HOLD + 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LOAD = HOLD_W'(LAP_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_ss_q;
    logic              r_lap_q;
    logic              r_clr_q;
    logic              w_ss_p;
    logic              w_lap_p;
    logic              w_clr_p;
    logic              w_capture;
    logic              w_clear;
    logic [HOLD_W-1:0] r_hold;
    logic [23:0]       r_lap;
    logic [23:0]       r_disp;
    logic [23:0]       w_live;
    logic [3:0]        r_lap_num;
    logic              r_sw_en;
    logic              r_sw_clr;
    logic              r_frozen;

    assign w_ss_p  = btn_ss  & ~r_ss_q;
    assign w_lap_p = btn_lap & ~r_lap_q;
    assign w_clr_p = btn_clr & ~r_clr_q;
    assign w_live  = {d5_in, d4_in, d3_in, d2_in, d1_in, d0_in};

    // Start/stop always wins over lap; clear is only honoured while stopped.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_clr_p)     w_clear = 1'b1;
                else if (w_ss_p) w_next  = S_RUN;
            end
            S_RUN: begin
                if (w_ss_p) begin
                    w_next = S_PAUSE;
                end else if (w_lap_p) begin
                    w_next    = S_LAP;
                    w_capture = 1'b1;
                end
            end
            S_LAP: begin
                if (w_ss_p) begin
                    w_next = S_PAUSE;
                end else if (w_lap_p) begin
                    w_capture = 1'b1;
                end else if (r_hold == '0) begin
                    w_next = S_RUN;
                end
            end
            S_PAUSE: begin
                if (w_clr_p) begin
                    w_next  = S_IDLE;
                    w_clear = 1'b1;
                end else if (w_ss_p) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ss_q    <= 1'b1;
            r_lap_q   <= 1'b1;
            r_clr_q   <= 1'b1;
            r_hold    <= '0;
            r_lap     <= '0;
            r_lap_num <= '0;
            r_disp    <= '0;
            r_sw_en   <= 1'b0;
            r_sw_clr  <= 1'b1;
            r_frozen  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ss_q   <= btn_ss;
            r_lap_q  <= btn_lap;
            r_clr_q  <= btn_clr;
            r_sw_en  <= (w_next == S_RUN) || (w_next == S_LAP);
            r_sw_clr <= w_clear;
            r_frozen <= (w_next == S_LAP);

            if (w_capture) begin
                r_hold <= c_HOLD_LOAD;
            end else if ((r_state == S_LAP) && (r_hold != '0)) begin
                r_hold <= r_hold - HOLD_W'(1);
            end

            if (w_clear) begin
                r_lap     <= '0;
                r_lap_num <= '0;
            end else if (w_capture) begin
                r_lap <= w_live;
                if (r_lap_num != 4'd9) r_lap_num <= r_lap_num + 4'd1;
            end

            // On the capture edge the live digits are the captured digits.
            r_disp <= ((w_next == S_LAP) && !w_capture) ? r_lap : w_live;
        end
    end

    assign sw_en       = r_sw_en;
    assign sw_clr      = r_sw_clr;
    assign disp_frozen = r_frozen;
    assign lap_num     = r_lap_num;
    assign disp_d5     = r_disp[23:20];
    assign disp_d4     = r_disp[19:16];
    assign disp_d3     = r_disp[15:12];
    assign disp_d2     = r_disp[11:8];
    assign disp_d1     = r_disp[7:4];
    assign disp_d0     = r_disp[3:0];

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Self-checking bench for stopwatch_ctrl (directed table, random
//            stimulus against a behavioural model, reset corner cases).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int LAP_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       btn_ss, btn_lap, btn_clr;
    logic [3:0] d5_in, d4_in, d3_in, d2_in, d1_in, d0_in;
    logic       sw_en, sw_clr, disp_frozen;
    logic [3:0] disp_d5, disp_d4, disp_d3, disp_d2, disp_d1, disp_d0;
    logic [3:0] lap_num;
    logic [23:0] disp_all;

    stopwatch_ctrl #(.LAP_HOLD(LAP_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_ss     (btn_ss),
        .btn_lap    (btn_lap),
        .btn_clr    (btn_clr),
        .d5_in      (d5_in),
        .d4_in      (d4_in),
        .d3_in      (d3_in),
        .d2_in      (d2_in),
        .d1_in      (d1_in),
        .d0_in      (d0_in),
        .sw_en      (sw_en),
        .sw_clr     (sw_clr),
        .disp_d5    (disp_d5),
        .disp_d4    (disp_d4),
        .disp_d3    (disp_d3),
        .disp_d2    (disp_d2),
        .disp_d1    (disp_d1),
        .disp_d0    (disp_d0),
        .disp_frozen(disp_frozen),
        .lap_num    (lap_num)
    );

    assign disp_all = {disp_d5, disp_d4, disp_d3, disp_d2, disp_d1, disp_d0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: counting flag, freeze flag with remaining cycles.
    logic        m_run, m_frozen, m_clr;
    int          m_left;
    int          m_laps;
    logic [23:0] m_cap, m_disp;
    logic        m_pss, m_pl, m_pc;

    typedef struct {
        logic        ss, lap, clr;
        logic [23:0] d;
        logic        en, sclr, fz;
        logic [3:0]  ln;
        logic [23:0] disp;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mk(input logic ss, l, c, input logic [23:0] d,
                                input logic en, sc, fz, input logic [3:0] ln,
                                input logic [23:0] dp);
        vec_t v;
        v.ss = ss; v.lap = l; v.clr = c; v.d = d;
        v.en = en; v.sclr = sc; v.fz = fz; v.ln = ln; v.disp = dp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_frozen = 1'b0; m_clr = 1'b1; m_left = 0; m_laps = 0;
        m_cap = '0; m_disp = '0;
        m_pss = 1'b1; m_pl = 1'b1; m_pc = 1'b1;
    endtask

    task automatic model_edge(input logic ss, l, c, input logic [23:0] d);
        logic ps, pl, pc;
        ps = ss & ~m_pss; pl = l & ~m_pl; pc = c & ~m_pc;
        m_pss = ss; m_pl = l; m_pc = c;
        m_clr = 1'b0;
        if (!m_run) begin
            if (pc) begin
                m_clr = 1'b1; m_laps = 0; m_cap = '0;
            end else if (ps) begin
                m_run = 1'b1;
            end
        end else if (ps) begin
            m_run = 1'b0; m_frozen = 1'b0;
        end else if (pl) begin
            m_frozen = 1'b1;
            m_left   = LAP_HOLD - 1;
            m_laps   = (m_laps >= 9) ? 9 : m_laps + 1;
            m_cap    = d;
        end else if (m_frozen) begin
            if (m_left == 0) m_frozen = 1'b0;
            else m_left--;
        end
        m_disp = m_frozen ? m_cap : d;
    endtask

    task automatic step(input logic ss, l, c, input logic [23:0] d);
        btn_ss = ss; btn_lap = l; btn_clr = c;
        {d5_in, d4_in, d3_in, d2_in, d1_in, d0_in} = d;
        @(posedge clk);
        #1;
        model_edge(ss, l, c, d);
        chk("m_sw_en",   32'(sw_en),       32'(m_run));
        chk("m_sw_clr",  32'(sw_clr),      32'(m_clr));
        chk("m_frozen",  32'(disp_frozen), 32'(m_frozen));
        chk("m_lap_num", 32'(lap_num),     32'(m_laps));
        chk("m_disp",    32'(disp_all),    32'(m_disp));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sw_en"},   32'(sw_en),       32'd0);
        chk({tag, "_sw_clr"},  32'(sw_clr),      32'd1);
        chk({tag, "_frozen"},  32'(disp_frozen), 32'd0);
        chk({tag, "_lap_num"}, 32'(lap_num),     32'd0);
        chk({tag, "_disp"},    32'(disp_all),    32'd0);
    endtask

    initial begin
        //            ss l  c  d           en sc fz ln disp
        tbl[0]  = mk(1, 0, 0, 24'h000000, 0, 0, 0, 0, 24'h000000);
        tbl[1]  = mk(0, 0, 0, 24'h000001, 0, 0, 0, 0, 24'h000001);
        tbl[2]  = mk(1, 0, 0, 24'h000002, 1, 0, 0, 0, 24'h000002);
        tbl[3]  = mk(1, 0, 0, 24'h000003, 1, 0, 0, 0, 24'h000003);
        tbl[4]  = mk(0, 0, 0, 24'h000004, 1, 0, 0, 0, 24'h000004);
        tbl[5]  = mk(0, 1, 0, 24'h012345, 1, 0, 1, 1, 24'h012345);
        tbl[6]  = mk(0, 1, 0, 24'h000100, 1, 0, 1, 1, 24'h012345);
        tbl[7]  = mk(0, 0, 0, 24'h000101, 1, 0, 1, 1, 24'h012345);
        tbl[8]  = mk(0, 0, 0, 24'h000102, 1, 0, 1, 1, 24'h012345);
        tbl[9]  = mk(0, 0, 0, 24'h000103, 1, 0, 0, 1, 24'h000103);
        tbl[10] = mk(0, 1, 0, 24'h000200, 1, 0, 1, 2, 24'h000200);
        tbl[11] = mk(0, 0, 0, 24'h000201, 1, 0, 1, 2, 24'h000200);
        tbl[12] = mk(0, 1, 0, 24'h000202, 1, 0, 1, 3, 24'h000202);
        tbl[13] = mk(0, 0, 0, 24'h000203, 1, 0, 1, 3, 24'h000202);
        tbl[14] = mk(1, 0, 0, 24'h000204, 0, 0, 0, 3, 24'h000204);
        tbl[15] = mk(0, 0, 1, 24'h000205, 0, 1, 0, 0, 24'h000205);
        tbl[16] = mk(0, 0, 0, 24'h000206, 0, 0, 0, 0, 24'h000206);
        tbl[17] = mk(1, 0, 0, 24'h000300, 1, 0, 0, 0, 24'h000300);
        tbl[18] = mk(0, 0, 1, 24'h000301, 1, 0, 0, 0, 24'h000301);
        tbl[19] = mk(0, 1, 0, 24'h000302, 1, 0, 1, 1, 24'h000302);
        tbl[20] = mk(0, 0, 1, 24'h000303, 1, 0, 1, 1, 24'h000302);
        tbl[21] = mk(1, 1, 0, 24'h000304, 0, 0, 0, 1, 24'h000304);
        tbl[22] = mk(0, 0, 0, 24'h000305, 0, 0, 0, 1, 24'h000305);
        tbl[23] = mk(1, 1, 0, 24'h000306, 1, 0, 0, 1, 24'h000306);
        tbl[24] = mk(0, 0, 0, 24'h000307, 1, 0, 0, 1, 24'h000307);
        tbl[25] = mk(1, 1, 0, 24'h000308, 0, 0, 0, 1, 24'h000308);
        tbl[26] = mk(0, 0, 0, 24'h000309, 0, 0, 0, 1, 24'h000309);
        tbl[27] = mk(1, 0, 1, 24'h000310, 0, 1, 0, 0, 24'h000310);
        tbl[28] = mk(0, 0, 0, 24'h000311, 0, 0, 0, 0, 24'h000311);
        tbl[29] = mk(0, 1, 0, 24'h000312, 0, 0, 0, 0, 24'h000312);
        tbl[30] = mk(1, 0, 0, 24'h000313, 1, 0, 0, 0, 24'h000313);

        // Reset with start/stop held: must not start after release.
        rst_n = 1'b0; btn_ss = 1'b1; btn_lap = 1'b0; btn_clr = 1'b0;
        {d5_in, d4_in, d3_in, d2_in, d1_in, d0_in} = 24'h0;
        model_reset();
        #12;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        #1;
        chk("rst_rel_sw_clr", 32'(sw_clr), 32'd1);

        for (int i = 0; i < 31; i++) begin
            step(tbl[i].ss, tbl[i].lap, tbl[i].clr, tbl[i].d);
            chk($sformatf("tbl_sw_en[%0d]", i),   32'(sw_en),       32'(tbl[i].en));
            chk($sformatf("tbl_sw_clr[%0d]", i),  32'(sw_clr),      32'(tbl[i].sclr));
            chk($sformatf("tbl_frozen[%0d]", i),  32'(disp_frozen), 32'(tbl[i].fz));
            chk($sformatf("tbl_lap_num[%0d]", i), 32'(lap_num),     32'(tbl[i].ln));
            chk($sformatf("tbl_disp[%0d]", i),    32'(disp_all),    32'(tbl[i].disp));
        end

        // Ten quick laps while running: counter saturates at 9.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 24'($urandom()));
            step(1'b0, 1'b0, 1'b0, 24'($urandom()));
        end
        chk("lap_saturate", 32'(lap_num), 32'd9);
        chk("lap_sat_frozen", 32'(disp_frozen), 32'd1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0), 24'($urandom()));
        end

        // Asynchronous reset in the middle of a lap freeze.
        step(1'b0, 1'b0, 1'b0, 24'h111111);
        if (!m_run) begin
            step(1'b1, 1'b0, 1'b0, 24'h222222);
            step(1'b0, 1'b0, 1'b0, 24'h333333);
        end
        step(1'b0, 1'b1, 1'b0, 24'h543210);
        chk("midlap_frozen", 32'(disp_frozen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst2_rel_sw_clr", 32'(sw_clr), 32'd1);
        step(1'b0, 1'b0, 1'b0, 24'h000001);
        step(1'b1, 1'b0, 1'b0, 24'h000002);
        step(1'b0, 1'b0, 1'b0, 24'h000003);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
